// File: rtl/mpu_table_writer.sv
// mpu_table_writer: bus initiator that programs or clears one MPU table entry
// (5 words) through a valid/ready memory bus, in an order that keeps the entry
// invalid until its code range is the last thing written (or the first thing
// cleared).
// Optional feature: define MPU_TABLE_WRITER_READBACK_EN to read back and
// compare all 5 words after the writes.
module mpu_table_writer #(
  parameter int unsigned MPU_START_ADDR = 768,
  parameter int unsigned MPU_ITEM_NUM   = 16,
  parameter int unsigned MPU_ITEM_LEN   = 5,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_clear,
  input  logic [3:0]  cmd_slot,
  input  logic [31:0] cmd_code_start,
  input  logic [31:0] cmd_code_end,
  input  logic [31:0] cmd_data_start,
  input  logic [31:0] cmd_data_end,
  input  logic [2:0]  cmd_acl,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_SLOT    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_RB      = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, GAP, FINISH} state_t;

  state_t      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        done_q, done_d;
  logic        clear_q, clear_d;
  logic [3:0]  slot_q, slot_d;
  logic [31:0] code_start_q, code_start_d;
  logic [31:0] code_end_q, code_end_d;
  logic [31:0] data_start_q, data_start_d;
  logic [31:0] data_end_q, data_end_d;
  logic [2:0]  acl_q, acl_d;
  logic        rd;

  logic [2:0]  k;
  logic [31:0] word;
  logic [21:0] byte_addr;

`ifdef MPU_TABLE_WRITER_READBACK_EN
  logic verify_q, verify_d;
  assign rd = verify_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign rd = 1'b0;
`endif

  // Map beat index to entry word offset and the word value/address for that beat
  always_comb begin
    k = 3'd0;
    if (clear_q) begin
      case (beat_q)
        3'd0:    k = 3'd1;
        3'd1:    k = 3'd0;
        3'd2:    k = 3'd4;
        3'd3:    k = 3'd2;
        default: k = 3'd3;
      endcase
    end else begin
      case (beat_q)
        3'd0:    k = 3'd4;
        3'd1:    k = 3'd2;
        3'd2:    k = 3'd3;
        3'd3:    k = 3'd0;
        default: k = 3'd1;
      endcase
    end
    word = 32'd0;
    if (!clear_q) begin
      case (k)
        3'd0:    word = code_start_q;
        3'd1:    word = code_end_q;
        3'd2:    word = data_start_q;
        3'd3:    word = data_end_q;
        default: word = {29'd0, acl_q};
      endcase
    end
    byte_addr = 22'(32'd4 * (MPU_START_ADDR + MPU_ITEM_LEN * {28'd0, slot_q} + {29'd0, k}));
  end

  // Next-state logic: command accept, write/read beats, timeout, completion
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    cnt_d        = cnt_q + 16'd1;
    err_d        = err_q;
    cmd_ready_d  = 1'b0;
    done_d       = 1'b0;
    clear_d      = clear_q;
    slot_d       = slot_q;
    code_start_d = code_start_q;
    code_end_d   = code_end_q;
    data_start_d = data_start_q;
    data_end_d   = data_end_q;
    acl_d        = acl_q;
`ifdef MPU_TABLE_WRITER_READBACK_EN
    verify_d     = verify_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        // Ready is raised one cycle after valid; transfer happens when both are high.
        cmd_ready_d = cmd_valid && !cmd_ready_q;
        if (cmd_valid && cmd_ready_q) begin
          clear_d      = cmd_clear;
          slot_d       = cmd_slot;
          code_start_d = cmd_code_start;
          code_end_d   = cmd_code_end;
          data_start_d = cmd_data_start;
          data_end_d   = cmd_data_end;
          acl_d        = cmd_acl;
          beat_d       = 3'd0;
          err_d        = ERR_OK;
`ifdef MPU_TABLE_WRITER_READBACK_EN
          verify_d     = 1'b0;
`endif
          if ({28'd0, cmd_slot} >= MPU_ITEM_NUM) begin
            err_d  = ERR_SLOT;
            done_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = GAP;
          cnt_d   = 16'd0;
`ifdef MPU_TABLE_WRITER_READBACK_EN
          if (verify_q && (mem_rdata != word) && (err_q == ERR_OK)) err_d = ERR_RB;
`endif
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = FINISH;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        // Responder may hold ready for several cycles; wait for it to drop.
        if (!mem_ready) begin
          cnt_d = 16'd0;
          if (beat_q == 3'd4) begin
`ifdef MPU_TABLE_WRITER_READBACK_EN
            if (!verify_q) begin
              verify_d = 1'b1;
              beat_d   = 3'd0;
              state_d  = REQ;
            end else begin
              state_d = FINISH;
              done_d  = 1'b1;
            end
`else
            state_d = FINISH;
            done_d  = 1'b1;
`endif
          end else begin
            beat_d  = beat_q + 3'd1;
            state_d = REQ;
          end
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = FINISH;
          done_d  = 1'b1;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-command registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      beat_q       <= 3'd0;
      cnt_q        <= 16'd0;
      err_q        <= ERR_OK;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      clear_q      <= 1'b0;
      slot_q       <= 4'd0;
      code_start_q <= 32'd0;
      code_end_q   <= 32'd0;
      data_start_q <= 32'd0;
      data_end_q   <= 32'd0;
      acl_q        <= 3'd0;
`ifdef MPU_TABLE_WRITER_READBACK_EN
      verify_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      clear_q      <= clear_d;
      slot_q       <= slot_d;
      code_start_q <= code_start_d;
      code_end_q   <= code_end_d;
      data_start_q <= data_start_d;
      data_end_q   <= data_end_d;
      acl_q        <= acl_d;
`ifdef MPU_TABLE_WRITER_READBACK_EN
      verify_q     <= verify_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_valid = (state_q == REQ);
  assign busy      = (state_q == REQ) || (state_q == GAP);
  assign mem_addr  = mem_valid ? byte_addr : 22'd0;
  assign mem_wdata = (mem_valid && !rd) ? word : 32'd0;
  assign mem_wstrb = (mem_valid && !rd) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_mpu_table_writer.sv
// Testbench for mpu_table_writer: scoreboard of expected bus beats and
// completion status, a randomized memory responder, and a second instance
// with a reduced entry count for the out-of-range slot case.
`timescale 1ns/1ps
module tb_mpu_table_writer;

  localparam int unsigned BASE = 768;
  localparam int unsigned LEN  = 5;
  localparam int          TMO  = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_valid8 = 1'b0, cmd_clear = 1'b0;
  logic [3:0]  cmd_slot = 4'd0;
  logic [31:0] cmd_cs = 0, cmd_ce = 0, cmd_ds = 0, cmd_de = 0;
  logic [2:0]  cmd_acl = 3'd0;
  logic        cmd_ready, mem_valid, busy, done;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  err;
  logic        cmd_ready8, mem_valid8, busy8, done8;
  logic        mem_ready8 = 1'b0;
  logic [31:0] mem_rdata8 = 32'd0;
  logic [21:0] mem_addr8;
  logic [31:0] mem_wdata8;
  logic [3:0]  mem_wstrb8;
  logic [1:0]  err8;

  always #5 clk = ~clk;

  mpu_table_writer #(.MPU_START_ADDR(BASE), .MPU_ITEM_NUM(16), .MPU_ITEM_LEN(LEN), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_clear(cmd_clear), .cmd_slot(cmd_slot), .cmd_code_start(cmd_cs), .cmd_code_end(cmd_ce),
    .cmd_data_start(cmd_ds), .cmd_data_end(cmd_de), .cmd_acl(cmd_acl),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err));

  mpu_table_writer #(.MPU_START_ADDR(BASE), .MPU_ITEM_NUM(8), .MPU_ITEM_LEN(LEN), .TIMEOUT(TMO)) dut8 (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
    .cmd_clear(cmd_clear), .cmd_slot(cmd_slot), .cmd_code_start(cmd_cs), .cmd_code_end(cmd_ce),
    .cmd_data_start(cmd_ds), .cmd_data_end(cmd_de), .cmd_acl(cmd_acl),
    .mem_valid(mem_valid8), .mem_ready(mem_ready8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_wstrb(mem_wstrb8), .mem_rdata(mem_rdata8), .busy(busy8), .done(done8), .err(err8));

  typedef struct packed {
    logic [21:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  txn_t        exp_q[$];
  int          exp_err_q[$];
  logic [31:0] mem_model [logic [21:0]];
  int          checks = 0, errors = 0;
  int          hs_total = 0, hs_base = 0, done_cnt = 0;
  int          stall_idx = -1, fixed_hold = 0;
  logic        corrupt_en = 1'b0;
  logic [21:0] corrupt_addr = 22'd0;
  logic        mv8_seen = 1'b0;

`ifdef MPU_TABLE_WRITER_READBACK_EN
  localparam int BEATS = 10;
`else
  localparam int BEATS = 5;
`endif

  function automatic logic [21:0] addr_of(input int slot, input int k);
    int unsigned w;
    w = BASE + LEN * slot + k;
    return 22'(w * 4);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the entry is a 5-word record; program/clear visit it in fixed orders.
  task automatic issue(input logic clr, input int slot, input logic [31:0] c0, input logic [31:0] c1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [2:0] a,
                       input int stall, input logic corrupt);
    int          prog_order[5];
    int          clr_order[5];
    logic [31:0] fld[5];
    int          n, k, e;
    bit          ok;
    txn_t        t;
    prog_order = '{4, 2, 3, 0, 1};
    clr_order  = '{1, 0, 4, 2, 3};
    fld = '{c0, c1, d0, d1, {29'd0, a}};
    if (clr) fld = '{0, 0, 0, 0, 0};
    n = (stall >= 0) ? stall : 5;
    for (int i = 0; i < n; i++) begin
      k = clr ? clr_order[i] : prog_order[i];
      t.addr = addr_of(slot, k); t.data = fld[k]; t.strb = 4'hF;
      exp_q.push_back(t);
    end
    e = (stall >= 0) ? 2 : 0;
`ifdef MPU_TABLE_WRITER_READBACK_EN
    if (stall < 0) begin
      for (int i = 0; i < 5; i++) begin
        k = clr ? clr_order[i] : prog_order[i];
        t.addr = addr_of(slot, k); t.data = fld[k]; t.strb = 4'h0;
        exp_q.push_back(t);
      end
      if (corrupt) e = 3;
    end
`endif
    exp_err_q.push_back(e);
    stall_idx    = stall;
    corrupt_en   = corrupt;
    corrupt_addr = addr_of(slot, 3);
    hs_base      = hs_total;
    cmd_clear = clr; cmd_slot = 4'(slot); cmd_cs = c0; cmd_ce = c1; cmd_ds = d0; cmd_de = d1; cmd_acl = a;
    cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cmd_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL cmd_ready: got 0 expected 1 within 20 cycles"); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Scramble inputs after acceptance; the latched command must be unaffected.
    cmd_clear = ~clr; cmd_slot = 4'($urandom); cmd_cs = $urandom; cmd_ce = $urandom;
    cmd_ds = $urandom; cmd_de = $urandom; cmd_acl = 3'($urandom);
  endtask

  task automatic wait_done(output int cycles);
    int start;
    start = done_cnt;
    cycles = 0;
    while (done_cnt == start && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
    end
    checks++;
    if (done_cnt == start) begin errors++; $display("FAIL done_wait: got no done expected done within 3000 cycles"); end
  endtask

  // Memory responder: answers requests after a random (or fixed) delay and holds ready 1..4 cycles.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge clk); #2;
      if (!resetn) begin
        mem_ready = 1'b0; hold = 0;
      end else if (mem_ready) begin
        hold--;
        if (hold <= 0) mem_ready = 1'b0;
      end else if (mem_valid && (hs_total - hs_base != stall_idx) &&
                   (fixed_hold > 0 || $urandom_range(0, 1) == 1)) begin
        mem_ready = 1'b1;
        hold = (fixed_hold > 0) ? fixed_hold : int'($urandom_range(1, 4));
        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'd0;
        if (corrupt_en && mem_addr == corrupt_addr) mem_rdata = mem_rdata ^ 32'h0000_0100;
      end
    end
  end

  // Monitor: pops expected beats and completion status as the DUT presents them.
  always @(negedge clk) begin
    txn_t t;
    int   e;
    if (resetn && mem_valid && mem_ready) begin
      hs_total++;
      $display("txn %0d: addr=%h wdata=%h wstrb=%h", hs_total, mem_addr, mem_wdata, mem_wstrb);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got addr %h expected no beat", mem_addr);
      end else begin
        t = exp_q.pop_front();
        if (mem_addr !== t.addr || mem_wstrb !== t.strb || (t.strb == 4'hF && mem_wdata !== t.data)) begin
          errors++;
          $display("FAIL beat: got addr=%h data=%h strb=%h expected addr=%h data=%h strb=%h",
                   mem_addr, mem_wdata, mem_wstrb, t.addr, t.data, t.strb);
        end
      end
      if (mem_wstrb == 4'hF) mem_model[mem_addr] = mem_wdata;
    end
    if (resetn && done) begin
      done_cnt++;
      checks++;
      if (exp_err_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done expected none");
      end else begin
        e = exp_err_q.pop_front();
        $display("done: err=%0d", err);
        if (int'(err) != e) begin errors++; $display("FAIL done_err: got %0d expected %0d", err, e); end
      end
      chk("beats_left_at_done", 64'(exp_q.size()), 64'd0);
    end
    if (cmd_ready && busy) begin
      errors++;
      $display("FAIL ready_while_busy: got cmd_ready=1 expected 0");
    end
    if (mem_valid8) mv8_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  n;
    bit  prev;
    logic [79:0] outs;
    repeat (3) @(posedge clk);
    #1;
    outs = {cmd_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, err};
    chk("reset_outputs", 64'(outs), 64'd0);
    chk("reset_outputs_hi", 64'(outs >> 64), 64'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Program slot 2 with ready held 2 cycles per beat
    fixed_hold = 2;
    issue(1'b0, 2, 32'h100, 32'h1FF, 32'h2000, 32'h2FFF, 3'b110, -1, 1'b0);
    wait_done(cyc);
    chk("slot2_beats", 64'(hs_total - hs_base), 64'(BEATS));

    // Clear slot 0
    issue(1'b1, 0, $urandom, $urandom, $urandom, $urandom, 3'b111, -1, 1'b0);
    wait_done(cyc);
    chk("clear0_beats", 64'(hs_total - hs_base), 64'(BEATS));

    // Highest slot with random ready timing
    fixed_hold = 0;
    issue(1'b0, 15, $urandom, $urandom, $urandom, $urandom, 3'b101, -1, 1'b0);
    wait_done(cyc);

    // Out-of-range slot on the reduced instance
    cmd_slot = 4'd9; mv8_seen = 1'b0; cmd_valid8 = 1'b1; n = 0; prev = 0;
    while (n < 10 && !done8) begin
      @(posedge clk); #1;
      n++;
      if (prev) cmd_valid8 = 1'b0;
      prev = cmd_ready8;
    end
    cmd_valid8 = 1'b0;
    chk("badslot_done_latency_ok", 64'(n <= 2 && done8), 64'd1);
    chk("badslot_err", 64'(err8), 64'd1);
    repeat (4) @(posedge clk); #1;
    chk("badslot_no_bus", 64'(mv8_seen), 64'd0);
    chk("badslot_idle", 64'({busy8, done8, cmd_ready8}), 64'd0);

    // Timeout on the third beat
    fixed_hold = 1;
    issue(1'b0, 5, $urandom, $urandom, $urandom, $urandom, 3'b011, 2, 1'b0);
    wait_done(cyc);
    chk("timeout_writes", 64'(hs_total - hs_base), 64'd2);
    chk("timeout_latency_ok", 64'(cyc >= TMO && cyc <= TMO + 20), 64'd1);
    chk("timeout_mem_valid_low", 64'(mem_valid), 64'd0);
    stall_idx = -1;
    repeat (2) @(posedge clk); #1;

    // Reset while the second beat is pending
    issue(1'b0, 7, $urandom, $urandom, $urandom, $urandom, 3'b100, -1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (hs_total - hs_base >= 1 && mem_valid) break;
      @(posedge clk); #1;
    end
    chk("midreset_in_beat2", 64'(mem_valid), 64'd1);
    resetn = 1'b0;
    #1;
    outs = {cmd_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, err};
    chk("midreset_outputs", 64'(outs), 64'd0);
    chk("midreset_outputs_hi", 64'(outs >> 64), 64'd0);
    exp_q.delete();
    exp_err_q.delete();
    repeat (3) @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk); #1;
    issue(1'b0, 7, $urandom, $urandom, $urandom, $urandom, 3'b100, -1, 1'b0);
    wait_done(cyc);
    chk("after_reset_beats", 64'(hs_total - hs_base), 64'(BEATS));

`ifdef MPU_TABLE_WRITER_READBACK_EN
    // Readback with a corrupted data_end word
    fixed_hold = 0;
    issue(1'b0, 4, $urandom, $urandom, $urandom, $urandom, 3'b010, -1, 1'b1);
    wait_done(cyc);
    chk("readback_beats", 64'(hs_total - hs_base), 64'd10);
    chk("readback_err", 64'(err), 64'd3);
    corrupt_en = 1'b0;
`endif

    // Random commands
    fixed_hold = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'($urandom), int'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom,
            3'($urandom), -1, 1'b0);
      wait_done(cyc);
      chk("rand_beats", 64'(hs_total - hs_base), 64'(BEATS));
    end

    repeat (3) @(posedge clk); #1;
    chk("no_pending_status", 64'(exp_err_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
